// File: rtl/rvl_usr_reg_bank_if.sv
// User register port and host 4-phase handshake port of the shared register bank.
interface rvl_usr_reg_bank_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  usr_ce;
    logic                  usr_we;
    logic [ADDR_WIDTH-1:0] usr_addr;
    logic [DATA_WIDTH-1:0] usr_wdata;
    logic [DATA_WIDTH-1:0] usr_rdata;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_rdata;
    logic                  host_err;

    modport master (
        output usr_ce, usr_we, usr_addr, usr_wdata,
        output host_req, host_we, host_addr, host_wdata,
        input  usr_rdata, host_ack, host_rdata, host_err
    );

    modport slave (
        input  usr_ce, usr_we, usr_addr, usr_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        output usr_rdata, host_ack, host_rdata, host_err
    );
endinterface

// File: rtl/rvl_usr_reg_bank.sv
// Register bank shared by a user register port and a 4-phase host port.
// Optional RVL_REG_WR_CNT_EN: read-only committed-user-write counter at address NUM_REGS.
module rvl_usr_reg_bank #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic               usr_clk,
    input  logic               usr_rst,
    rvl_usr_reg_bank_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    // One extra bit so the limit compare never wraps, whatever ADDR_WIDTH is.
    localparam logic [ADDR_WIDTH:0] NREG_LIM = AW1'(NUM_REGS);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    data_t      regs_q [NUM_REGS];
    state_e     state_q, state_d;
    data_t      usr_rdata_q, usr_rdata_d;
    data_t      host_rdata_q, host_rdata_d;
    logic       host_ack_q, host_ack_d;
    logic       host_err_q, host_err_d;

    logic       usr_in_rng_c, host_in_rng_c;
    logic       usr_wr_c, host_wr_c;
    logic [IDX_W-1:0] usr_idx_c, host_idx_c;
    data_t      usr_rd_val_c, host_rd_val_c;

    assign usr_in_rng_c  = {1'b0, bus.usr_addr}  < NREG_LIM;
    assign host_in_rng_c = {1'b0, bus.host_addr} < NREG_LIM;
    assign usr_idx_c     = bus.usr_addr[IDX_W-1:0];
    assign host_idx_c    = bus.host_addr[IDX_W-1:0];
    assign usr_wr_c      = bus.usr_ce && bus.usr_we && usr_in_rng_c;

`ifdef RVL_REG_WR_CNT_EN
    data_t wr_cnt_q;
    logic  usr_cnt_sel_c, host_cnt_sel_c;

    assign usr_cnt_sel_c  = {1'b0, bus.usr_addr}  == NREG_LIM;
    assign host_cnt_sel_c = {1'b0, bus.host_addr} == NREG_LIM;

    // Saturating count of user writes that actually landed in the bank.
    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            wr_cnt_q <= '0;
        end else if (usr_wr_c && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + DATA_WIDTH'(1);
        end
    end

    always_comb begin
        usr_rd_val_c  = '0;
        host_rd_val_c = '0;
        if (usr_in_rng_c)        usr_rd_val_c  = regs_q[usr_idx_c];
        else if (usr_cnt_sel_c)  usr_rd_val_c  = wr_cnt_q;
        if (host_in_rng_c)       host_rd_val_c = regs_q[host_idx_c];
        else if (host_cnt_sel_c) host_rd_val_c = wr_cnt_q;
    end
`else
    always_comb begin
        usr_rd_val_c  = '0;
        host_rd_val_c = '0;
        if (usr_in_rng_c)  usr_rd_val_c  = regs_q[usr_idx_c];
        if (host_in_rng_c) host_rd_val_c = regs_q[host_idx_c];
    end
`endif

    // Host FSM next state plus all registered outputs.
    always_comb begin
        state_d      = state_q;
        host_rdata_d = host_rdata_q;
        host_err_d   = host_err_q;
        host_wr_c    = 1'b0;
        usr_rdata_d  = usr_rdata_q;

        if (bus.usr_ce && !bus.usr_we) begin
            usr_rdata_d = usr_rd_val_c;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.host_req) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.host_we) begin
                    if (host_in_rng_c) begin
                        // A same-address user write takes priority over the host.
                        if (usr_wr_c && (bus.usr_addr == bus.host_addr)) begin
                            host_err_d = 1'b1;
                        end else begin
                            host_wr_c = 1'b1;
                        end
                    end
                end else begin
                    host_rdata_d = host_rd_val_c;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!bus.host_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        host_ack_d = (state_d == ST_ACK);
    end

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            state_q      <= ST_IDLE;
            usr_rdata_q  <= '0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            host_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            usr_rdata_q  <= usr_rdata_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            host_err_q   <= host_err_d;
        end
    end

    // Storage; reads see pre-edge values, so read-during-write returns old data.
    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (host_wr_c) regs_q[host_idx_c] <= bus.host_wdata;
            if (usr_wr_c)  regs_q[usr_idx_c]  <= bus.usr_wdata;
        end
    end

    assign bus.usr_rdata  = usr_rdata_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_err   = host_err_q;

endmodule

// File: tb/tb_rvl_usr_reg_bank.sv
// Directed bench for rvl_usr_reg_bank: user port, host handshake, collisions, reset abort.
module tb_rvl_usr_reg_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    rvl_usr_reg_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    rvl_usr_reg_bank #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .NUM_REGS  (16)
    ) dut (
        .usr_clk(clk),
        .usr_rst(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic usr_write(input logic [15:0] addr, input logic [15:0] data);
        bus.usr_ce = 1'b1; bus.usr_we = 1'b1; bus.usr_addr = addr; bus.usr_wdata = data;
        @(negedge clk);
        bus.usr_ce = 1'b0; bus.usr_we = 1'b0;
    endtask

    task automatic usr_rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        bus.usr_ce = 1'b1; bus.usr_we = 1'b0; bus.usr_addr = addr;
        @(negedge clk);
        bus.usr_ce = 1'b0;
        check(tag, 32'(bus.usr_rdata), 32'(exp));
    endtask

    // Full host transaction; optional user access presented during the ACCESS cycle.
    task automatic host_op(input string tag, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic u_en, input logic u_we,
                           input logic [15:0] u_addr, input logic [15:0] u_wdata);
        int lat;
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
        @(negedge clk);
        bus.usr_ce = u_en; bus.usr_we = u_we; bus.usr_addr = u_addr; bus.usr_wdata = u_wdata;
        @(negedge clk);
        bus.usr_ce = 1'b0; bus.usr_we = 1'b0;
        lat = 2;
        while (!bus.host_ack && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ack_lat"}, 32'(lat), 32'd2);
        @(negedge clk);
        check({tag, "_ack_hold"}, 32'(bus.host_ack), 32'd1);
        bus.host_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_drop"}, 32'(bus.host_ack), 32'd0);
    endtask

    initial begin
        bus.usr_ce = 1'b0; bus.usr_we = 1'b0; bus.usr_addr = '0; bus.usr_wdata = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack",   32'(bus.host_ack),   32'd0);
        check("rst_err",   32'(bus.host_err),   32'd0);
        check("rst_hrd",   32'(bus.host_rdata), 32'd0);
        check("rst_urd",   32'(bus.usr_rdata),  32'd0);
        usr_rd_chk("rd3_reset", 16'd3, 16'h0000);

        // Basic user write/read, then host read of the same register.
        usr_write(16'd5, 16'h1234);
        usr_rd_chk("rd5", 16'd5, 16'h1234);
        @(negedge clk);
        check("urd_hold", 32'(bus.usr_rdata), 32'h1234);
        host_op("hrd5", 1'b0, 16'd5, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000);
        check("hrd5_data", 32'(bus.host_rdata), 32'h1234);

        // Host write and user write to different addresses both commit.
        host_op("hwr15", 1'b1, 16'd15, 16'hBEEF, 1'b1, 1'b1, 16'd0, 16'h0001);
        check("hwr15_err", 32'(bus.host_err), 32'd0);
        check("hrd_keep", 32'(bus.host_rdata), 32'h1234);
        usr_rd_chk("rd15", 16'd15, 16'hBEEF);
        usr_rd_chk("rd0",  16'd0,  16'h0001);

        // Same-address collision: user wins, sticky error.
        host_op("coll", 1'b1, 16'd2, 16'hAAAA, 1'b1, 1'b1, 16'd2, 16'h5555);
        check("coll_err", 32'(bus.host_err), 32'd1);
        usr_rd_chk("rd2_coll", 16'd2, 16'h5555);

        // User read while host writes the same address sees the old value.
        host_op("rdw", 1'b1, 16'd7, 16'h7777, 1'b1, 1'b0, 16'd7, 16'h0000);
        check("rdw_old", 32'(bus.usr_rdata), 32'h0000);
        usr_rd_chk("rd7", 16'd7, 16'h7777);
        check("err_sticky", 32'(bus.host_err), 32'd1);

        // Host read while user writes the same address sees the old value.
        host_op("hrdw", 1'b0, 16'd5, 16'h0000, 1'b1, 1'b1, 16'd5, 16'h9999);
        check("hrdw_old", 32'(bus.host_rdata), 32'h1234);
        usr_rd_chk("rd5_new", 16'd5, 16'h9999);

        // Out-of-range accesses must not alias onto low registers.
        host_op("oor_w", 1'b1, 16'h0020, 16'hFFFF, 1'b0, 1'b0, 16'd0, 16'h0000);
        usr_rd_chk("oor_rd0", 16'd0, 16'h0001);
        host_op("oor_r", 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000);
        check("oor_hrd", 32'(bus.host_rdata), 32'h0000);
        usr_write(16'h0010, 16'hDEAD);
        usr_write(16'h0012, 16'hCAFE);
        usr_rd_chk("oor_rd2", 16'd2, 16'h5555);
        usr_rd_chk("oor_rd12", 16'h0012, 16'h0000);

`ifdef RVL_REG_WR_CNT_EN
        // Committed user writes so far: 5, 0, 2 (collision), 5 -> 4.
        usr_rd_chk("cnt_u", 16'd16, 16'h0004);
        host_op("cnt_h", 1'b0, 16'd16, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000);
        check("cnt_hrd", 32'(bus.host_rdata), 32'h0004);
        for (int i = 0; i < 65531; i++) usr_write(16'd1, 16'h0042);
        usr_rd_chk("cnt_max", 16'd16, 16'hFFFF);
        usr_write(16'd1, 16'h0043);
        usr_rd_chk("cnt_sat", 16'd16, 16'hFFFF);
`else
        usr_rd_chk("addr16_u", 16'd16, 16'h0000);
        host_op("addr16_h", 1'b0, 16'd16, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000);
        check("addr16_hrd", 32'(bus.host_rdata), 32'h0000);
`endif

        // Reset in ACCESS aborts the pending host write.
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'd9; bus.host_wdata = 16'h9999;
        @(negedge clk);
        #1 rst = 1'b1;
        bus.host_req = 1'b0;
        #1 check("rst_acc_ack", 32'(bus.host_ack), 32'd0);
        check("rst_acc_err", 32'(bus.host_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        usr_rd_chk("rst_rd9", 16'd9, 16'h0000);
        usr_rd_chk("rst_rd2", 16'd2, 16'h0000);

        // Reset in ACK drops the acknowledge immediately.
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'd0;
        repeat (2) @(negedge clk);
        check("ack_pre_rst", 32'(bus.host_ack), 32'd1);
        #2 rst = 1'b1;
        #1 check("ack_rst_drop", 32'(bus.host_ack), 32'd0);
        bus.host_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("ack_post_rst", 32'(bus.host_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
